// File: rtl/scalar_write_back_unit.sv
// Scalar write-back unit: queues ALU/load results and retires them one at a
// time into the register file through an IDLE/ISSUE/WAIT handshake.
module scalar_write_back_unit #(
  parameter int unsigned LEN   = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy_in,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [LEN-1:0]  alu_data,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic [LEN-1:0]  mem_data,
  output logic            in_ready,
  output logic [1:0]      rf_signal,
  output logic [4:0]      wb_rd,
  output logic [LEN-1:0]  wb_data,
  output logic            write_back_enabled,
  input  logic [1:0]      rf_status,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wb_idle
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [1:0] RF_NOP          = 2'd0;
  localparam logic [1:0] SCALAR_RF_WRITE = 2'd1;
  localparam logic [1:0] RF_FINISHED     = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state;
  logic [4:0]        fifo_rd   [DEPTH];
  logic [LEN-1:0]    fifo_data [DEPTH];
  logic [DEPTH-1:0]  fifo_vld;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              accept;
  logic              alu_push;
  logic              mem_push;
  logic              pop;
  logic [PTR_W-1:0]  mem_ptr;
  logic [PTR_W-1:0]  tail_next;
  logic [CNT_W-1:0]  n_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Two free slots guarantee both producers can land in the same cycle.
  assign in_ready = (count <= CNT_W'(DEPTH - 2));
  assign wb_idle  = (count == '0) && (state == IDLE);

  assign accept   = rdy_in & in_ready;
  assign alu_push = accept & alu_valid & (alu_rd != 5'd0);
  assign mem_push = accept & mem_valid & (mem_rd != 5'd0);
  assign pop      = rdy_in & (state == WAIT) & (rf_status == RF_FINISHED);

  // ALU result takes the tail slot first; the load result follows it.
  assign mem_ptr   = alu_push ? ptr_inc(tail) : tail;
  assign tail_next = mem_push ? ptr_inc(mem_ptr) : mem_ptr;
  assign n_push    = CNT_W'(alu_push) + CNT_W'(mem_push);

  // Payload storage; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      fifo_rd[tail]   <= alu_rd;
      fifo_data[tail] <= alu_data;
    end
    if (mem_push) begin
      fifo_rd[mem_ptr]   <= mem_rd;
      fifo_data[mem_ptr] <= mem_data;
    end
  end

  // Queue bookkeeping, FSM and registered register-file request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= IDLE;
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      fifo_vld           <= '0;
      write_back_enabled <= 1'b0;
      rf_signal          <= RF_NOP;
      wb_rd              <= '0;
      wb_data            <= '0;
    end else if (rdy_in) begin
      if (pop) begin
        fifo_vld[head] <= 1'b0;
        head           <= ptr_inc(head);
      end
      if (alu_push) fifo_vld[tail]    <= 1'b1;
      if (mem_push) fifo_vld[mem_ptr] <= 1'b1;
      tail  <= tail_next;
      count <= count + n_push - CNT_W'(pop);

      case (state)
        IDLE: begin
          write_back_enabled <= 1'b0;
          rf_signal          <= RF_NOP;
          if (count != '0) begin
            state              <= ISSUE;
            wb_rd              <= fifo_rd[head];
            wb_data            <= fifo_data[head];
            write_back_enabled <= 1'b1;
            rf_signal          <= SCALAR_RF_WRITE;
          end
        end
        ISSUE: begin
          state              <= WAIT;
          write_back_enabled <= 1'b0;
          rf_signal          <= RF_NOP;
        end
        WAIT: begin
          write_back_enabled <= 1'b0;
          rf_signal          <= RF_NOP;
          if (rf_status == RF_FINISHED) state <= IDLE;
        end
        default: begin
          state              <= IDLE;
          write_back_enabled <= 1'b0;
          rf_signal          <= RF_NOP;
        end
      endcase
    end
  end

  // Decode hazard: the head stays valid until popped, covering in-flight writes.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i] && (rs1 != 5'd0) && (fifo_rd[i] == rs1)) rs1_busy = 1'b1;
      if (fifo_vld[i] && (rs2 != 5'd0) && (fifo_rd[i] == rs2)) rs2_busy = 1'b1;
    end
  end

endmodule

// File: doc/scalar_write_back_unit.md
SCALAR_WRITE_BACK_UNIT -- requirements
Module: scalar_write_back_unit

Interface
REQ-001 SHALL have parameter LEN, default 32: scalar data width.
REQ-002 SHALL have parameter DEPTH, default 4: write-back queue entries; PTR_W, default 2: log2(DEPTH).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1: reset; synchronous and active-low.
REQ-005 SHALL have port rdy_in  input  1: global enable; low freezes all state.
REQ-006 SHALL have ports alu_valid input 1, alu_rd input 5, alu_data input LEN: ALU result offer.
REQ-007 SHALL have ports mem_valid input 1, mem_rd input 5, mem_data input LEN: load result offer.
REQ-008 SHALL have port in_ready  output  1: producers may offer results this cycle.
REQ-009 SHALL have ports rf_signal output 2, wb_rd output 5, wb_data output LEN, write_back_enabled output 1: register-file write request.
REQ-010 SHALL have port rf_status  input  2: register-file completion status (`RF_NOP` / `RF_FINISHED` from defines.v).
REQ-011 SHALL have ports rs1 input 5, rs2 input 5, rs1_busy output 1, rs2_busy output 1: decode-stage hazard query.
REQ-012 SHALL have port wb_idle  output  1: queue empty and FSM in IDLE.

Function
REQ-013 SHALL hold results in a circular FIFO of DEPTH entries {rd, data}, with head/tail pointers of PTR_W bits wrapping DEPTH-1 -> 0 and a count of PTR_W+1 bits.
REQ-014 SHALL drive in_ready = 1 iff count <= DEPTH-2, so two results can always be accepted in one cycle.
REQ-015 SHALL, on a cycle with rdy_in=1 and in_ready=1, enqueue each offer whose valid=1 and rd!=0; if both qualify, the ALU entry goes first.
REQ-016 SHALL silently drop offers with rd=0 (x0 never written) and SHALL ignore all offers while in_ready=0.
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-018 SHALL, in IDLE with count>0, move to ISSUE on the next edge, latching the head entry into wb_rd/wb_data.
REQ-019 SHALL, in ISSUE, drive write_back_enabled=1 and rf_signal=`SCALAR_RF_WRITE` for exactly one cycle, then enter WAIT.
REQ-020 SHALL, in WAIT, hold write_back_enabled=0 and rf_signal=`RF_NOP`; when rf_status==`RF_FINISHED`, pop the head and return to IDLE.
REQ-021 SHALL allow an enqueue and a pop in the same cycle; count changes by net (+2, +1, 0, -1).
REQ-022 SHALL drive write_back_enabled=0 and rf_signal=`RF_NOP` in every state other than ISSUE.
REQ-023 SHALL assert rsN_busy (combinationally) iff rsN!=0 and rsN matches rd of any valid FIFO entry, including the head in ISSUE/WAIT.
REQ-024 SHALL, with rdy_in=0, hold FSM, pointers, count and outputs unchanged, and SHALL treat any enqueue or rf_status in that cycle as absent.
REQ-025 SHALL leave the order of register writes equal to the enqueue order.
REQ-026 SHALL drive wb_idle=1 iff count==0 and state==IDLE.

Reset
REQ-027 SHALL, on posedge clk with rst=0, set state=IDLE, head=tail=0, count=0, and clear all FIFO valid bits.
REQ-028 SHALL, during and after reset, drive write_back_enabled=0, rf_signal=`RF_NOP`, wb_rd=0, wb_data=0, in_ready=1, rs1_busy=rs2_busy=0, wb_idle=1.
REQ-029 SHALL, on reset during ISSUE or WAIT, abandon the in-flight write and drop all queued entries.
REQ-030 SHALL give reset priority over rdy_in.

Verification
REQ-031 SHALL cover single write: alu_valid, rd=5, data=0xDEADBEEF -> 1 cycle later ISSUE with wb_rd=5 and write_back_enabled=1 for one cycle; rf_status=`RF_FINISHED` -> wb_idle=1.
REQ-032 SHALL cover simultaneous offers: ALU rd=3/0x11 and MEM rd=4/0x22 in one cycle -> writes issue in order rd=3, then rd=4.
REQ-033 SHALL cover fill/wrap: 6 results while rf_status is stalled -> in_ready=0 at count>=3, no entry is lost, pointers wrap, and all writes drain in order.
REQ-034 SHALL cover x0 drop and hazard: offer rd=0 -> nothing is enqueued; queued rd=7 with rs1=7 -> rs1_busy=1 until its pop; rs2=0 -> rs2_busy=0.
REQ-035 SHALL cover rdy_in=0 during WAIT, with rf_status=`RF_FINISHED` and an offer present -> no pop, no enqueue, outputs held.
REQ-036 SHALL cover reset in WAIT with 2 queued entries -> the next cycle shows all REQ-028 values, and no further write_back_enabled pulse occurs.
